// File: rtl/tcdm_port_arbiter.sv
// rtl/tcdm_port_arbiter.sv - round-robin share of one TCDM initiator port with in-order response routing
// Optional per-requester stall counters: define TCDM_PORT_ARB_STALL_CNT_EN.
module tcdm_port_arbiter #(
  parameter int NumReq         = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int BeWidth        = DataWidth / 8,
  parameter int MaxOutstanding = 4,
  parameter bit WriteRespOn    = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    add_i,
  input  logic [NumReq-1:0]                   wen_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   vld_o,
  output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
  output logic                                req_o,
  output logic [AddrWidth-1:0]                add_o,
  output logic                                wen_o,
  output logic [DataWidth-1:0]                wdata_o,
  output logic [BeWidth-1:0]                  be_o,
  input  logic                                gnt_i,
  input  logic                                vld_i,
  input  logic [DataWidth-1:0]                rdata_i,
`ifdef TCDM_PORT_ARB_STALL_CNT_EN
  input  logic                                stall_clr_i,
  output logic [NumReq-1:0][15:0]             stall_cnt_o,
`endif
  output logic                                err_o
);

  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]    r_rr;
  logic [IdW-1:0]    r_fifo [MaxOutstanding];
  logic [PtrW-1:0]   r_wr;
  logic [PtrW-1:0]   r_rd;
  logic [CntW-1:0]   r_count;
  logic              r_err;

  logic [IdW-1:0]    w_winner;
  int                w_s;
  logic              w_any;
  logic              w_full;
  logic              w_empty;
  logic              w_req;
  logic              w_hs;
  logic              w_wen;
  logic              w_push;
  logic              w_pop;
  logic [NumReq-1:0] w_gnt;
  logic [NumReq-1:0] w_vld;

  // Descending scan so the candidate closest to the pointer is assigned last and wins.
  always_comb begin
    w_winner = r_rr;
    w_s      = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      w_s = int'(r_rr) + k;
      if (w_s >= NumReq) w_s = w_s - NumReq;
      if (req_i[w_s[IdW-1:0]]) w_winner = w_s[IdW-1:0];
    end
  end

  assign w_any   = |req_i;
  assign w_full  = (r_count == CntW'(MaxOutstanding));
  assign w_empty = (r_count == '0);
  assign w_req   = w_any & ~w_full;
  assign w_hs    = w_req & gnt_i;
  assign w_wen   = w_any & wen_i[w_winner];
  assign w_push  = w_hs & (~w_wen | WriteRespOn);
  assign w_pop   = vld_i & ~w_empty;

  always_comb begin
    w_gnt = '0;
    w_vld = '0;
    if (w_hs)  w_gnt[w_winner]     = 1'b1;
    if (w_pop) w_vld[r_fifo[r_rd]] = 1'b1;
  end

  assign req_o   = ~rst_i & w_req;
  assign gnt_o   = rst_i ? '0 : w_gnt;
  assign vld_o   = rst_i ? '0 : w_vld;
  assign rdata_o = rst_i ? '0 : {NumReq{rdata_i}};
  assign add_o   = (rst_i | ~w_any) ? '0 : add_i[w_winner];
  assign wen_o   = ~rst_i & w_wen;
  assign wdata_o = (rst_i | ~w_any) ? '0 : wdata_i[w_winner];
  assign be_o    = (rst_i | ~w_any) ? '0 : be_i[w_winner];
  assign err_o   = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
    end else begin
      if (w_hs) r_rr <= (w_winner == IdW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
      if (w_push) begin
        r_fifo[r_wr] <= w_winner;
        r_wr         <= (r_wr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (vld_i & w_empty) r_err <= 1'b1;
    end
  end

`ifdef TCDM_PORT_ARB_STALL_CNT_EN
  logic [NumReq-1:0][15:0] r_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (stall_clr_i) begin
          r_stall[i] <= '0;
        end else if (req_i[i] & ~w_gnt[i] & (r_stall[i] != 16'hFFFF)) begin
          r_stall[i] <= r_stall[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall;
`endif

endmodule
